// File: rtl/la_bec_alu.sv
// Operand loader and multi-cycle add/subtract unit driven from logic-analyzer probes.
// Exports the result, carry/borrow, a done pulse, a one-hot FSM status and a sticky overrun flag.
module la_bec_alu #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wr_en,
   input  logic             wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   input  logic             mode,
   input  logic             clr_err,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             done,
   output logic             busy,
   output logic [2:0]       status,
   output logic             overrun
);

   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_BUSY = 2'b10,
      S_DONE = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] reg_a_q, reg_a_d;
   logic [WIDTH-1:0] reg_b_q, reg_b_d;
   logic             mode_q, mode_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             overrun_q, overrun_d;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   diff_s;

   // The top bit of the widened difference is the unsigned borrow (A < B).
   assign sum_s  = {1'b0, reg_a_q} + {1'b0, reg_b_q};
   assign diff_s = {1'b0, reg_a_q} - {1'b0, reg_b_q};

   // Next-state, operand-load and result-capture logic.
   always_comb begin
      state_d   = state_q;
      reg_a_d   = reg_a_q;
      reg_b_d   = reg_b_q;
      mode_d    = mode_q;
      count_d   = count_q;
      result_d  = result_q;
      carry_d   = carry_q;
      overrun_d = overrun_q;

      if (clr_err) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end

      case (state_q)
         S_IDLE, S_LOAD: begin
            if (wr_en) begin
               if (wr_sel) begin
                  reg_b_d = wr_data;
               end else begin
                  reg_a_d = wr_data;
               end
            end else begin
               reg_a_d = reg_a_q;
            end
            if (start) begin
               mode_d  = mode;
               count_d = {CW{1'b0}};
               state_d = S_BUSY;
            end else if (wr_en) begin
               state_d = S_LOAD;
            end else begin
               state_d = state_q;
            end
         end
         S_BUSY: begin
            // Violations set the flag after the clear so that set wins.
            if (wr_en || start) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_d;
            end
            if (count_q == CNT_LAST) begin
               count_d  = {CW{1'b0}};
               state_d  = S_DONE;
               result_d = mode_q ? diff_s[WIDTH-1:0] : sum_s[WIDTH-1:0];
               carry_d  = mode_q ? diff_s[WIDTH] : sum_s[WIDTH];
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         S_DONE: begin
            if (wr_en || start) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_d;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_q   <= S_IDLE;
         reg_a_q   <= {WIDTH{1'b0}};
         reg_b_q   <= {WIDTH{1'b0}};
         mode_q    <= 1'b0;
         count_q   <= {CW{1'b0}};
         result_q  <= {WIDTH{1'b0}};
         carry_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         reg_a_q   <= reg_a_d;
         reg_b_q   <= reg_b_d;
         mode_q    <= mode_d;
         count_q   <= count_d;
         result_q  <= result_d;
         carry_q   <= carry_d;
         overrun_q <= overrun_d;
      end
   end

   // Status is a direct decode of the state register.
   always_comb begin
      status = 3'b000;
      case (state_q)
         S_IDLE:  status = 3'b000;
         S_LOAD:  status = 3'b100;
         S_BUSY:  status = 3'b010;
         S_DONE:  status = 3'b001;
         default: status = 3'b000;
      endcase
   end

   assign busy    = (state_q == S_BUSY);
   assign done    = (state_q == S_DONE);
   assign result  = result_q;
   assign carry   = carry_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_la_bec_alu.sv
// Directed self-checking bench for la_bec_alu at WIDTH=8, LATENCY=4.
module tb_la_bec_alu;

   localparam int WIDTH   = 8;
   localparam int LATENCY = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wr_en, wr_sel, start, mode, clr_err;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] result;
   logic             carry, done, busy, overrun;
   logic [2:0]       status;

   int n_assert = 0;
   int n_fail   = 0;

   la_bec_alu #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst_n),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_data (wr_data),
      .start   (start),
      .mode    (mode),
      .clr_err (clr_err),
      .result  (result),
      .carry   (carry),
      .done    (done),
      .busy    (busy),
      .status  (status),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic sel, input logic [WIDTH-1:0] data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_data = data;
      tick();
      wr_en = 1'b0;
      chk("status_load", {29'd0, status}, 32'h4);
   endtask

   // Launch on the next edge, then check LATENCY busy cycles, the done cycle and the return to IDLE.
   task automatic op(input string tag, input logic m, input logic [WIDTH-1:0] exp_res, input logic exp_c);
      start = 1'b1;
      mode  = m;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         chk({tag, "_busy"}, {31'd0, busy}, 32'h1);
         chk({tag, "_nodone"}, {31'd0, done}, 32'h0);
         tick();
      end
      chk({tag, "_done"}, {31'd0, done}, 32'h1);
      chk({tag, "_stdone"}, {29'd0, status}, 32'h1);
      chk({tag, "_res"}, {24'd0, result}, {24'd0, exp_res});
      chk({tag, "_carry"}, {31'd0, carry}, {31'd0, exp_c});
      tick();
      chk({tag, "_idle"}, {29'd0, status}, 32'h0);
      chk({tag, "_done_off"}, {31'd0, done}, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_data = 8'h00;
      start = 1'b0; mode = 1'b0; clr_err = 1'b0;
      tick();
      tick();
      chk("rst_status", {29'd0, status}, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'h0);
      chk("rst_done", {31'd0, done}, 32'h0);
      chk("rst_result", {24'd0, result}, 32'h0);
      chk("rst_carry", {31'd0, carry}, 32'h0);
      chk("rst_overrun", {31'd0, overrun}, 32'h0);
      rst_n = 1'b1;

      // Basic add
      wr(1'b0, 8'h25);
      wr(1'b1, 8'h1A);
      op("add_basic", 1'b0, 8'h3F, 1'b0);

      // Carry out and borrow
      wr(1'b0, 8'hF0);
      wr(1'b1, 8'h20);
      op("add_carry", 1'b0, 8'h10, 1'b1);
      wr(1'b0, 8'h10);
      wr(1'b1, 8'h30);
      op("sub_borrow", 1'b1, 8'hE0, 1'b1);

      // Retained operands, launched straight from IDLE
      op("retained", 1'b0, 8'h40, 1'b0);

      // Overrun: write and start while busy are ignored
      start = 1'b1; mode = 1'b0;
      tick();
      wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'hFF; start = 1'b1;
      tick();
      wr_en = 1'b0; start = 1'b0;
      chk("ovr_set", {31'd0, overrun}, 32'h1);
      tick();
      tick();
      chk("ovr_busy_last", {31'd0, busy}, 32'h1);
      chk("ovr_sticky", {31'd0, overrun}, 32'h1);
      tick();
      chk("ovr_done", {31'd0, done}, 32'h1);
      chk("ovr_res", {24'd0, result}, 32'h40);
      chk("ovr_carry", {31'd0, carry}, 32'h0);
      clr_err = 1'b1; start = 1'b1;
      tick();
      clr_err = 1'b0; start = 1'b0;
      chk("ovr_set_wins", {31'd0, overrun}, 32'h1);
      chk("ovr_start_in_done_ignored", {29'd0, status}, 32'h0);
      tick();
      chk("ovr_no_relaunch", {31'd0, busy}, 32'h0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("ovr_cleared", {31'd0, overrun}, 32'h0);
      op("ovr_operands_kept", 1'b0, 8'h40, 1'b0);

      // Reset during the second busy cycle
      wr(1'b0, 8'hC8);
      wr(1'b1, 8'h64);
      start = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0;
      tick();
      chk("midrst_busy2", {31'd0, busy}, 32'h1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_status", {29'd0, status}, 32'h0);
      chk("midrst_busy", {31'd0, busy}, 32'h0);
      chk("midrst_result", {24'd0, result}, 32'h0);
      chk("midrst_carry", {31'd0, carry}, 32'h0);
      for (int i = 0; i < 8; i++) begin
         chk("midrst_no_done", {31'd0, done}, 32'h0);
         tick();
      end

      // Write and start in the same LOAD cycle
      wr(1'b0, 8'h03);
      wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'h05;
      op("wr_start_same", 1'b0, 8'h08, 1'b0);

      // Equal operands subtract: zero result, no borrow
      op("sub_equal_seed", 1'b0, 8'h08, 1'b0);
      wr(1'b0, 8'h05);
      op("sub_equal", 1'b1, 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
